multi_cycle_sequencer: RTL and testbench

- Sequences the processor datapath instruction by instruction. Each instruction passes through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK.
- Drives the 3-bit ALUOp consumed by ALU_Control, plus the register-file, PC, IR and memory strobes.
- Sits between instruction memory/decode and the datapath. Stretches memory states with a ready handshake and guards them with a wait timeout.

---
 rtl/risc_ctrl_pkg.sv | 49 ++++
 rtl/multi_cycle_sequencer_mem_wait_timer.sv | 30 +++
 rtl/multi_cycle_sequencer.sv | 168 ++++++++++++++++
 tb/tb_multi_cycle_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/risc_ctrl_pkg.sv
// Shared control definitions: state encodings, opcode classes and ALUOp codes.
// Pure declarations; no latency or backpressure.
package risc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd6
    } state_e;

    localparam int unsigned CLS_RARITH = 0;
    localparam int unsigned CLS_SHIFTC = 1;
    localparam int unsigned CLS_SHIFTV = 2;
    localparam int unsigned CLS_ADDI   = 3;
    localparam int unsigned CLS_COMPI  = 4;
    localparam int unsigned CLS_LW     = 5;
    localparam int unsigned CLS_SW     = 6;
    localparam int unsigned CLS_BRANCH = 7;
    localparam int unsigned CLS_JUMP   = 8;

    localparam logic [2:0] ALU_PASS   = 3'b000;
    localparam logic [2:0] ALU_ARITH  = 3'b001;
    localparam logic [2:0] ALU_SHIFTC = 3'b010;
    localparam logic [2:0] ALU_SHIFTV = 3'b011;
    localparam logic [2:0] ALU_ADD    = 3'b100;
    localparam logic [2:0] ALU_CMP    = 3'b101;
    localparam logic [2:0] ALU_BRANCH = 3'b110;

    function automatic logic class_legal(input int unsigned cls);
        return cls <= CLS_JUMP;
    endfunction

    function automatic logic [2:0] class_alu_op(input int unsigned cls);
        case (cls)
            CLS_RARITH:                return ALU_ARITH;
            CLS_SHIFTC:                return ALU_SHIFTC;
            CLS_SHIFTV:                return ALU_SHIFTV;
            CLS_ADDI, CLS_LW, CLS_SW:  return ALU_ADD;
            CLS_COMPI:                 return ALU_CMP;
            CLS_BRANCH:                return ALU_BRANCH;
            default:                   return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_sequencer_mem_wait_timer.sv
// Counts mem_ready-low cycles in a memory state; expired_o is combinational in the
// cycle the count would reach MEM_WAIT_MAX with ready still low (ready wins).
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic ready_i,
    output logic expired_o
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !ready_i && (cnt_q != CW'(MEM_WAIT_MAX))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_o = en_i && !ready_i && (cnt_q == CW'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control; memory states stall on mem_ready
// with a wait timeout into a sticky FAULT. Perf counters built only with SEQ_PERF_COUNTERS_EN.
module multi_cycle_sequencer
    import risc_ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 6,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic [2:0]          alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch_eval,
    output logic                reg_write,
    output logic                instr_done,
    output logic                illegal_instr,
    output logic                mem_timeout,
    output logic [2:0]          state_out,
    output logic [31:0]         cycle_count,
    output logic [31:0]         instr_count
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                mem_timeout_q;
    logic [2:0]          exe_alu_op;
    logic                is_lw, is_sw, is_ctrl;
    logic                timer_clr, timer_en, timer_expired;
    state_e              retire_state;

    assign exe_alu_op   = class_alu_op(32'(op_q));
    assign is_lw        = (op_q == OPCODE_W'(CLS_LW));
    assign is_sw        = (op_q == OPCODE_W'(CLS_SW));
    assign is_ctrl      = (op_q == OPCODE_W'(CLS_BRANCH)) || (op_q == OPCODE_W'(CLS_JUMP));
    assign retire_state = run ? S_FETCH : S_IDLE;

    assign timer_en  = (state_q == S_FETCH) || (state_q == S_MEMORY);
    assign timer_clr = ((state_d == S_FETCH) || (state_d == S_MEMORY)) && (state_d != state_q);

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_wait (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .ready_i   (mem_ready),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        alu_op        = ALU_PASS;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch_eval   = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (!class_legal(32'(opcode))) begin
                    illegal_instr = 1'b1;
                    state_d       = retire_state;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_op = exe_alu_op;
                if (is_ctrl) begin
                    branch_eval = 1'b1;
                    instr_done  = 1'b1;
                    state_d     = retire_state;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                // ALUOp held so the effective address stays stable while stalled
                alu_op    = exe_alu_op;
                mem_read  = is_lw;
                mem_write = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = retire_state;
                    end
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                alu_op     = exe_alu_op;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = retire_state;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (state_d == S_FAULT) mem_timeout_q <= 1'b1;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign state_out   = state_q;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] cycle_count_q, instr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_FAULT)) cycle_count_q <= cycle_count_q + 32'd1;
            if (instr_done) instr_count_q <= instr_count_q + 32'd1;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed bench for multi_cycle_sequencer: per-cycle expected outputs go through a scoreboard queue.
module tb_multi_cycle_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
    localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_FAULT = 3'd6;

    localparam logic [8:0] MR = 9'h100, MW = 9'h080, IW = 9'h040, PW = 9'h020, BE = 9'h010;
    localparam logic [8:0] RW = 9'h008, DN = 9'h004, IL = 9'h002, TO = 9'h001, NONE = 9'h000;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] alu;
        logic [8:0] stb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, run, mem_ready;
    logic [5:0]  opcode;
    logic [2:0]  alu_op, state_out;
    logic        mem_read, mem_write, ir_write, pc_write, branch_eval;
    logic        reg_write, instr_done, illegal_instr, mem_timeout;
    logic [31:0] cycle_count, instr_count;
    logic [8:0]  obs_stb;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int unsigned cc_model = 0;
    int unsigned ic_model = 0;

    always #5 clk = ~clk;

    multi_cycle_sequencer #(.OPCODE_W(6), .MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .branch_eval(branch_eval), .reg_write(reg_write),
        .instr_done(instr_done), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
        .state_out(state_out), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    assign obs_stb = {mem_read, mem_write, ir_write, pc_write, branch_eval,
                      reg_write, instr_done, illegal_instr, mem_timeout};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        logic [31:0] cc_exp, ic_exp;
`ifdef SEQ_PERF_COUNTERS_EN
        cc_exp = cc_model;
        ic_exp = ic_model;
`else
        cc_exp = 32'd0;
        ic_exp = 32'd0;
`endif
        chk({tag, ":cycle_count"}, cycle_count, cc_exp);
        chk({tag, ":instr_count"}, instr_count, ic_exp);
    endtask

    // One clock: drive at posedge+1, compare at negedge, return at next posedge+1.
    task automatic cyc(input string tag, input logic r, input logic [5:0] opc, input logic rdy,
                       input logic [2:0] st, input logic [2:0] alu, input logic [8:0] stb);
        exp_t e;
        run       = r;
        opcode    = opc;
        mem_ready = rdy;
        sb_q.push_back('{st: st, alu: alu, stb: stb});
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, ":state"}, 32'(state_out), 32'(e.st));
        chk({tag, ":alu_op"}, 32'(alu_op), 32'(e.alu));
        chk({tag, ":strobes"}, 32'(obs_stb), 32'(e.stb));
        chk_counters(tag);
        if (!rst && e.st != ST_IDLE && e.st != ST_FAULT) cc_model++;
        if (!rst && (e.stb & DN) != NONE) ic_model++;
        @(posedge clk);
        #1;
    endtask

    task automatic seq_alu(input logic [5:0] opc, input logic [2:0] alu, input logic r_end);
        string t;
        t = $sformatf("op%0d", opc);
        cyc({t, "_F"}, 1'b1, opc, 1'b1, ST_FETCH, 3'b000, MR | IW | PW);
        cyc({t, "_D"}, 1'b1, opc, 1'b1, ST_DECODE, 3'b000, NONE);
        cyc({t, "_E"}, r_end, 6'h3F, 1'b1, ST_EXEC, alu, NONE);
        cyc({t, "_W"}, r_end, 6'h3F, 1'b1, ST_WB, alu, RW | DN);
    endtask

    task automatic seq_br(input logic [5:0] opc, input logic [2:0] alu);
        string t;
        t = $sformatf("op%0d", opc);
        cyc({t, "_F"}, 1'b1, opc, 1'b1, ST_FETCH, 3'b000, MR | IW | PW);
        cyc({t, "_D"}, 1'b1, opc, 1'b1, ST_DECODE, 3'b000, NONE);
        cyc({t, "_E"}, 1'b1, 6'h3F, 1'b1, ST_EXEC, alu, BE | DN);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cc_model = 0;
        ic_model = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 1'b0, 6'd0, 1'b0, ST_IDLE, 3'b000, NONE);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 6'd0; mem_ready = 1'b0;
        apply_reset();

        // R-arith, branch, lw with a 3-cycle stall, sw, illegal opcode
        cyc("idle_go", 1'b1, 6'd0, 1'b1, ST_IDLE, 3'b000, NONE);
        seq_alu(6'd0, 3'b001, 1'b1);
        seq_br(6'd7, 3'b110);
        cyc("lw_F", 1'b1, 6'd5, 1'b1, ST_FETCH, 3'b000, MR | IW | PW);
        cyc("lw_D", 1'b1, 6'd5, 1'b1, ST_DECODE, 3'b000, NONE);
        cyc("lw_E", 1'b1, 6'd0, 1'b1, ST_EXEC, 3'b100, NONE);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw_Mwait%0d", i), 1'b1, 6'd0, 1'b0, ST_MEM, 3'b100, MR);
        cyc("lw_Mrdy", 1'b1, 6'd0, 1'b1, ST_MEM, 3'b100, MR);
        cyc("lw_W", 1'b1, 6'd0, 1'b1, ST_WB, 3'b100, RW | DN);
        cyc("sw_F", 1'b1, 6'd6, 1'b1, ST_FETCH, 3'b000, MR | IW | PW);
        cyc("sw_D", 1'b1, 6'd6, 1'b1, ST_DECODE, 3'b000, NONE);
        cyc("sw_E", 1'b1, 6'd0, 1'b1, ST_EXEC, 3'b100, NONE);
        cyc("sw_M", 1'b1, 6'd0, 1'b1, ST_MEM, 3'b100, MW | DN);
        cyc("ill_F", 1'b1, 6'h3F, 1'b1, ST_FETCH, 3'b000, MR | IW | PW);
        cyc("ill_D", 1'b1, 6'h3F, 1'b1, ST_DECODE, 3'b000, IL);

        // Remaining ALU classes and jump, then addi with run dropped in EXECUTE
        seq_alu(6'd1, 3'b010, 1'b1);
        seq_alu(6'd2, 3'b011, 1'b1);
        seq_alu(6'd4, 3'b101, 1'b1);
        seq_br(6'd8, 3'b000);
        seq_alu(6'd3, 3'b100, 1'b0);
        cyc("idle_stop0", 1'b0, 6'd0, 1'b1, ST_IDLE, 3'b000, NONE);
        cyc("idle_stop1", 1'b0, 6'd0, 1'b1, ST_IDLE, 3'b000, NONE);

        // mem_ready on the 15th FETCH cycle: no fault
        cyc("nf_idle", 1'b1, 6'd0, 1'b0, ST_IDLE, 3'b000, NONE);
        for (int i = 1; i < 15; i++)
            cyc($sformatf("nf_Fwait%0d", i), 1'b1, 6'd0, 1'b0, ST_FETCH, 3'b000, MR);
        cyc("nf_F15", 1'b1, 6'd0, 1'b1, ST_FETCH, 3'b000, MR | IW | PW);
        cyc("nf_D", 1'b1, 6'd0, 1'b1, ST_DECODE, 3'b000, NONE);
        cyc("nf_E", 1'b0, 6'd0, 1'b1, ST_EXEC, 3'b001, NONE);
        cyc("nf_W", 1'b0, 6'd0, 1'b1, ST_WB, 3'b001, RW | DN);
        cyc("nf_idle2", 1'b0, 6'd0, 1'b1, ST_IDLE, 3'b000, NONE);

        // Asynchronous reset in the middle of a stalled load
        cyc("ar_idle", 1'b1, 6'd5, 1'b1, ST_IDLE, 3'b000, NONE);
        cyc("ar_F", 1'b1, 6'd5, 1'b1, ST_FETCH, 3'b000, MR | IW | PW);
        cyc("ar_D", 1'b1, 6'd5, 1'b1, ST_DECODE, 3'b000, NONE);
        cyc("ar_E", 1'b1, 6'd5, 1'b0, ST_EXEC, 3'b100, NONE);
        cyc("ar_M", 1'b1, 6'd5, 1'b0, ST_MEM, 3'b100, MR);
        #1 rst = 1'b1;
        cc_model = 0;
        ic_model = 0;
        #1;
        chk("ar_async:state", 32'(state_out), 32'(ST_IDLE));
        chk("ar_async:alu_op", 32'(alu_op), 32'd0);
        chk("ar_async:strobes", 32'(obs_stb), 32'd0);
        chk_counters("ar_async");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc("ar_after", 1'b0, 6'd0, 1'b0, ST_IDLE, 3'b000, NONE);

        // FETCH starved of mem_ready: FAULT after 15 cycles, sticky until reset
        cyc("to_idle", 1'b1, 6'd0, 1'b0, ST_IDLE, 3'b000, NONE);
        for (int i = 1; i <= 15; i++)
            cyc($sformatf("to_Fwait%0d", i), 1'b1, 6'd0, 1'b0, ST_FETCH, 3'b000, MR);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("to_fault%0d", i), 1'b1, 6'd0, 1'b1, ST_FAULT, 3'b000, TO);
        apply_reset();
        cyc("post_fault_idle", 1'b0, 6'd0, 1'b1, ST_IDLE, 3'b000, NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
